// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter/sequencer in front of the single-port 64-byte data memory.
// Port 0 is the CPU load/store unit, port 1 is the debug/DMA loader. A granted
// request is registered in IDLE, presented to the memory for exactly one
// ACCESS cycle, and completed with a one-cycle done pulse in RESP. Req seen in
// IDLE at cycle N gives done at cycle N+2; peak rate is one access per 3 cycles.
//
// Parameters:
//   ADDR_W      address width of requesters and memory
//   DATA_W      data width (byte lane is DATA_W/2)
//   FIXED_PRIO  0 = round-robin on contention, 1 = port 0 always wins ties
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req*/we*/word*          request, write enable, 2-byte (1) or 1-byte (0)
//   addr*/wdata*            byte address, write data (byte writes use [7:0])
//   done*/err*              completion pulse, error flag valid with done
//   rdata                   read data, valid from the done cycle of a read
//   busy                    high whenever the sequencer is not in IDLE
//   mem_wmem/memc/addr/din  memory write strobe, size select, address, data
//   mem_dout                combinational read data from the memory
//
// Build option:
//   DMEM_ARB_MISALIGN_CHK_EN  when defined, a word access with addr[0]=1 is
//   not sent to the memory and completes with err set; otherwise err* are 0
//   and the memory aligns misaligned word accesses itself.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              word0,
  input  logic              word1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_wmem,
  output logic              mem_memc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              win;        // latched winner id (0 = port 0)
  logic              rr_ptr;     // port favoured on the next tie
  logic              grant;
  logic              win_sel;
  logic              misalign;

  logic              l_we;
  logic              l_word;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  assign misalign = l_word & l_addr[0];
`else
  assign misalign = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

  // Winner selection; only consumed in the IDLE grant cycle.
  always_comb begin
    win_sel = 1'b0;
    if (req0 && req1) begin
      win_sel = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
    end else if (req1) begin
      win_sel = 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    err0       = 1'b0;
    err1       = 1'b0;
    mem_wmem   = 1'b0;
    mem_memc   = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A rejected misaligned access leaves the memory bus fully idle.
        if (!misalign) begin
          mem_wmem = l_we;
          mem_memc = l_word;
          mem_addr = l_addr;
          mem_din  = l_wdata;
        end
        state_next = ST_RESP;
      end
      ST_RESP: begin
        done0      = ~win;
        done1      = win;
        err0       = ~win & misalign;
        err1       = win & misalign;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      win    <= 1'b0;
      rr_ptr <= 1'b0;
      rdata  <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        win <= win_sel;
      end
      if (state == ST_ACCESS && !l_we && !misalign) begin
        rdata <= mem_dout;
      end
      if (state == ST_RESP) begin
        rr_ptr <= ~win;
      end
    end
  end

  // NOTE: the request payload is deliberately not reset; it is only observed
  // in ACCESS/RESP, which always follow a grant that reloads it.
  always_ff @(posedge clk) begin
    if (grant) begin
      l_we    <= win_sel ? we1    : we0;
      l_word  <= win_sel ? word1  : word0;
      l_addr  <= win_sel ? addr1  : addr0;
      l_wdata <= win_sel ? wdata1 : wdata0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A behavioural 64-byte big-endian
// memory sits behind the round-robin instance; a second instance with
// FIXED_PRIO=1 shares the requester inputs to show tie behaviour. Directed
// transactions come from a table of {request, expected result} records; the
// reset, withdrawal and contention cases are written out as sequences.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, word0, word1;
  logic [15:0] addr0, addr1, wdata0, wdata1;

  logic        done0, done1, err0, err1, busy;
  logic [15:0] rdata;
  logic        mem_wmem, mem_memc;
  logic [15:0] mem_addr, mem_din, mem_dout;

  logic        done0_f, done1_f, err0_f, err1_f, busy_f;
  logic [15:0] rdata_f;
  logic        mem_wmem_f, mem_memc_f;
  logic [15:0] mem_addr_f, mem_din_f;
  logic [15:0] mem_dout_f;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .word0(word0), .word1(word1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy),
    .mem_wmem(mem_wmem), .mem_memc(mem_memc), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .word0(word0), .word1(word1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0_f), .done1(done1_f), .err0(err0_f), .err1(err1_f),
    .rdata(rdata_f), .busy(busy_f),
    .mem_wmem(mem_wmem_f), .mem_memc(mem_memc_f), .mem_addr(mem_addr_f),
    .mem_din(mem_din_f), .mem_dout(mem_dout_f)
  );

  assign mem_dout_f = '0;

  // Behavioural memory: 64 bytes, big-endian words, word accesses ignore a[0].
  logic [7:0] mem [64];
  logic [5:0] ma;
  assign ma = mem_addr[5:0];

  always_comb begin
    mem_dout = '0;
    if (mem_memc) mem_dout = {mem[{ma[5:1], 1'b0}], mem[{ma[5:1], 1'b1}]};
    else          mem_dout = {8'h00, mem[ma]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (mem_wmem) begin
      if (mem_memc) begin
        mem[{ma[5:1], 1'b0}] <= mem_din[15:8];
        mem[{ma[5:1], 1'b1}] <= mem_din[7:0];
      end else begin
        mem[ma] <= mem_din[7:0];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;  // rdata after completion
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic drive_idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; word0 = 0; word1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int          lat;
    int          wcnt;
    logic [15:0] acc_addr;
    logic        acc_busy;
    logic [1:0]  dn;
    logic [1:0]  er;
    logic        gated;
    gated = MIS && v.word && v.addr[0];
    @(posedge clk); #1;
    if (v.port) begin
      req1 = 1; we1 = v.we; word1 = v.word; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1; we0 = v.we; word0 = v.word; addr0 = v.addr; wdata0 = v.wdata;
    end
    lat = 99; wcnt = 0; acc_addr = 'x; acc_busy = 0; dn = 0; er = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (mem_wmem) wcnt++;
      if (c == 1) begin
        acc_addr = mem_addr;
        acc_busy = busy;
      end
      if (done0 || done1) begin
        lat = c;
        dn  = {done1, done0};
        er  = {err1, err0};
        break;
      end
    end
    drive_idle();
    check($sformatf("v%0d latency", idx), lat, 2);
    check($sformatf("v%0d done", idx), {30'd0, dn}, v.port ? 2 : 1);
    check($sformatf("v%0d err", idx), {30'd0, er}, v.exp_err ? (v.port ? 2 : 1) : 0);
    check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    check($sformatf("v%0d wmem_cycles", idx), wcnt, (v.we && !gated) ? 1 : 0);
    check($sformatf("v%0d access_addr", idx), acc_addr, gated ? 16'h0 : v.addr);
    check($sformatf("v%0d access_busy", idx), acc_busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // port we word addr wdata exp_rdata exp_err
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 16'hABCD, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000, 16'hABCD, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0006, 16'h1234, 16'hABCD, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0007, 16'hFF5A, 16'hABCD, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h0006, 16'h0000, 16'h125A, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000, 16'h005A, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h00AB, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'h1111, 16'h00AB, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 16'h7788, 16'h00AB, MIS};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 16'h0000, MIS ? 16'h1111 : 16'h7788, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0005, 16'h99EE, MIS ? 16'h1111 : 16'h7788, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 16'hABEE, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, 16'hABEE, MIS};

    // Reset held two cycles with a pending request.
    drive_idle();
    rst_n = 0;
    req0  = 1; word0 = 1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("reset done", {done1, done0}, 0);
      check("reset wmem", mem_wmem, 0);
      check("reset rdata", rdata, 0);
      check("reset busy", busy, 0);
      check("reset mem_addr", mem_addr, 0);
    end
    rst_n = 1;
    lat = 99;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done0 || done1) begin
        lat = c;
        check("post-reset done", {done1, done0}, 1);
        break;
      end
    end
    drive_idle();
    check("post-reset latency", lat, 2);

    for (int i = 0; i < 13; i++) run_txn(vecs[i], i);

    // Withdrawal: req1 for the grant cycle only.
    @(posedge clk); #1;
    req1 = 1; word1 = 1; addr1 = 16'h0006;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) req1 = 0;
      check($sformatf("withdraw done c%0d", c), {done1, done0}, (c == 2) ? 2 : 0);
      check($sformatf("withdraw busy c%0d", c), busy, (c <= 2) ? 1 : 0);
      check($sformatf("withdraw fp done c%0d", c), {done1_f, done0_f}, (c == 2) ? 2 : 0);
    end
    drive_idle();
    check("withdraw rdata", rdata, 16'h125A);

    // Contention: both ports held high; last served was port 1.
    @(posedge clk); #1;
    req0 = 1; word0 = 1; addr0 = 16'h0004;
    req1 = 1; word1 = 1; addr1 = 16'h0002;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check($sformatf("rr done c%0d", c), {done1, done0},
            (c % 3 != 2) ? 0 : ((c == 2 || c == 8) ? 1 : 2));
      check($sformatf("fixed done c%0d", c), {done1_f, done0_f}, (c % 3 == 2) ? 1 : 0);
      if (c == 8)  check("rr rdata port0", rdata, 16'hABEE);
      if (c == 11) check("rr rdata port1", rdata, MIS ? 16'h1111 : 16'h7788);
    end
    drive_idle();
    @(posedge clk); #1;
    check("idle after contention", busy, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
